// File: rtl/cprv_hazard_controller.sv
// -----------------------------------------------------------------------------
// cprv_hazard_controller
//
// Pipeline sequencing controller for the 5-stage RV64 core. It works alongside
// the EX-stage forwarding network and covers the cases forwarding cannot:
//   - load-use hazards: load data is forwarded only from WB, so a dependent
//     consumer in ID needs two bubbles;
//   - multi-cycle MUL/DIV occupancy of EX;
//   - taken-branch / jump flushes.
// All outputs are combinational from the registered state plus the inputs of
// the current cycle. While rst_n is low every output is forced to 0.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   valid_id             ID stage holds a real instruction
//   rs1_addr_id/rs2_*    source registers of the ID instruction
//   rs1_used_id/rs2_*    ID instruction actually reads that source
//   valid_ex             EX stage holds a real instruction
//   opcode_ex            EX opcode (loads are 7'b0000011)
//   rd_addr_ex, rd_en_ex EX destination register and its write enable
//   muldiv_ex            EX instruction is an M-extension op
//   muldiv_is_div_ex     the M-op is of the DIV/REM class
//   branch_taken_ex      EX resolved a taken branch or jump
//   stall_if             hold the PC and the IF/ID register
//   stall_id             hold the ID/EX register contents
//   stall_ex             hold the EX/MEM input (EX re-executes)
//   bubble_ex            load a NOP into ID/EX at the next edge
//   flush_if, flush_id   invalidate IF/ID, ID/EX at the next edge
//   muldiv_go            single-cycle start pulse to the M-unit
//   muldiv_done          last EX cycle of an M-op
//   busy                 controller is not in RUN
// -----------------------------------------------------------------------------
module cprv_hazard_controller #(
   parameter int MUL_LATENCY = 3,
   parameter int DIV_LATENCY = 34,
   parameter int CNT_WIDTH   = $clog2(DIV_LATENCY + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid_id,
   input  logic [4:0] rs1_addr_id,
   input  logic [4:0] rs2_addr_id,
   input  logic       rs1_used_id,
   input  logic       rs2_used_id,
   input  logic       valid_ex,
   input  logic [6:0] opcode_ex,
   input  logic [4:0] rd_addr_ex,
   input  logic       rd_en_ex,
   input  logic       muldiv_ex,
   input  logic       muldiv_is_div_ex,
   input  logic       branch_taken_ex,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       bubble_ex,
   output logic       flush_if,
   output logic       flush_id,
   output logic       muldiv_go,
   output logic       muldiv_done,
   output logic       busy
);

   localparam logic [6:0]           OPC_LOAD  = 7'b0000011;
   localparam logic [CNT_WIDTH-1:0] MUL_LAT_C = CNT_WIDTH'(MUL_LATENCY);
   localparam logic [CNT_WIDTH-1:0] DIV_LAT_C = CNT_WIDTH'(DIV_LATENCY);
   localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TWO_C     = CNT_WIDTH'(2);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MD_BUSY  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

   logic                 load_use;
   logic                 md;
   logic [CNT_WIDTH-1:0] lat_sel;
   logic                 lat_one;

   // Hazard detection on the current EX/ID pair.
   always_comb begin
      load_use = valid_ex & valid_id & rd_en_ex & (opcode_ex == OPC_LOAD) &
                 (rd_addr_ex != 5'd0) &
                 ((rs1_used_id & (rs1_addr_id == rd_addr_ex)) |
                  (rs2_used_id & (rs2_addr_id == rd_addr_ex)));
      md       = valid_ex & muldiv_ex;
      lat_sel  = muldiv_is_div_ex ? DIV_LAT_C : MUL_LAT_C;
      lat_one  = (lat_sel == ONE_C);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic. A branch wins over an M-op, which wins over load-use.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         RUN: begin
            if (branch_taken_ex) begin
               state_next = RUN;
            end else if (md) begin
               // The first EX cycle of the op is spent here in RUN and the
               // final one (cnt==0) in MD_BUSY, so L-2 countdown steps remain.
               if (!lat_one) begin
                  state_next = MD_BUSY;
                  cnt_next   = lat_sel - TWO_C;
               end
            end else if (load_use) begin
               state_next = LU_STALL;
            end
         end
         LU_STALL: begin
            state_next = RUN;
         end
         MD_BUSY: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - ONE_C;
            end else begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
            cnt_next   = '0;
         end
      endcase
   end

   // Output logic. Gated by rst_n so the outputs drop the moment reset is
   // asserted, even though the RUN-state outputs depend on live inputs.
   always_comb begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if    = 1'b0;
      flush_id    = 1'b0;
      muldiv_go   = 1'b0;
      muldiv_done = 1'b0;
      busy        = 1'b0;
      if (rst_n) begin
         case (state_reg)
            RUN: begin
               if (branch_taken_ex) begin
                  flush_if = 1'b1;
                  flush_id = 1'b1;
               end else if (md) begin
                  muldiv_go = 1'b1;
                  if (lat_one) begin
                     muldiv_done = 1'b1;
                  end else begin
                     stall_if = 1'b1;
                     stall_id = 1'b1;
                     stall_ex = 1'b1;
                  end
               end else if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            LU_STALL: begin
               // Second bubble: the load is in MEM, EX inputs are irrelevant.
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               busy      = 1'b1;
            end
            MD_BUSY: begin
               busy = 1'b1;
               if (cnt_reg != '0) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  stall_ex = 1'b1;
               end else begin
                  muldiv_done = 1'b1;
               end
            end
            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cprv_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_cprv_hazard_controller
//
// Self-checking bench. u0 uses the default latencies (MUL 3, DIV 34); u1
// overrides MUL_LATENCY to 1. Expected output vectors are pushed into a
// scoreboard queue when stimulus is driven and popped at the falling edge.
// Output vector order:
//   {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id,
//    muldiv_go, muldiv_done, busy}
// -----------------------------------------------------------------------------
module tb_cprv_hazard_controller;

   localparam logic [8:0] SIF  = 9'h100;
   localparam logic [8:0] SID  = 9'h080;
   localparam logic [8:0] SEX  = 9'h040;
   localparam logic [8:0] BUB  = 9'h020;
   localparam logic [8:0] FIF  = 9'h010;
   localparam logic [8:0] FID  = 9'h008;
   localparam logic [8:0] GO   = 9'h004;
   localparam logic [8:0] DONE = 9'h002;
   localparam logic [8:0] BUSY = 9'h001;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ADD = 7'b0110011;

   typedef struct packed {
      logic       vid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       vex;
      logic [6:0] op;
      logic [4:0] rd;
      logic       rd_en;
      logic       md;
      logic       is_div;
      logic       br;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] exp;
      string      tag;
   } vec_t;

   typedef struct {
      logic [8:0] exp;
      string      tag;
      bit         use_u1;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic       valid_id;
   logic [4:0] rs1_addr_id;
   logic [4:0] rs2_addr_id;
   logic       rs1_used_id;
   logic       rs2_used_id;
   logic       valid_ex;
   logic [6:0] opcode_ex;
   logic [4:0] rd_addr_ex;
   logic       rd_en_ex;
   logic       muldiv_ex;
   logic       muldiv_is_div_ex;
   logic       branch_taken_ex;

   logic u0_stall_if, u0_stall_id, u0_stall_ex, u0_bubble_ex, u0_flush_if;
   logic u0_flush_id, u0_muldiv_go, u0_muldiv_done, u0_busy;
   logic u1_stall_if, u1_stall_id, u1_stall_ex, u1_bubble_ex, u1_flush_if;
   logic u1_flush_id, u1_muldiv_go, u1_muldiv_done, u1_busy;

   logic [8:0] act0, act1;
   assign act0 = {u0_stall_if, u0_stall_id, u0_stall_ex, u0_bubble_ex,
                  u0_flush_if, u0_flush_id, u0_muldiv_go, u0_muldiv_done, u0_busy};
   assign act1 = {u1_stall_if, u1_stall_id, u1_stall_ex, u1_bubble_ex,
                  u1_flush_if, u1_flush_id, u1_muldiv_go, u1_muldiv_done, u1_busy};

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   sb_t  sb_q[$];

   cprv_hazard_controller u0 (
      .clk(clk), .rst_n(rst_n),
      .valid_id(valid_id), .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .valid_ex(valid_ex), .opcode_ex(opcode_ex), .rd_addr_ex(rd_addr_ex),
      .rd_en_ex(rd_en_ex), .muldiv_ex(muldiv_ex), .muldiv_is_div_ex(muldiv_is_div_ex),
      .branch_taken_ex(branch_taken_ex),
      .stall_if(u0_stall_if), .stall_id(u0_stall_id), .stall_ex(u0_stall_ex),
      .bubble_ex(u0_bubble_ex), .flush_if(u0_flush_if), .flush_id(u0_flush_id),
      .muldiv_go(u0_muldiv_go), .muldiv_done(u0_muldiv_done), .busy(u0_busy)
   );

   cprv_hazard_controller #(.MUL_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .valid_id(valid_id), .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .valid_ex(valid_ex), .opcode_ex(opcode_ex), .rd_addr_ex(rd_addr_ex),
      .rd_en_ex(rd_en_ex), .muldiv_ex(muldiv_ex), .muldiv_is_div_ex(muldiv_is_div_ex),
      .branch_taken_ex(branch_taken_ex),
      .stall_if(u1_stall_if), .stall_id(u1_stall_id), .stall_ex(u1_stall_ex),
      .bubble_ex(u1_bubble_ex), .flush_if(u1_flush_if), .flush_id(u1_flush_id),
      .muldiv_go(u1_muldiv_go), .muldiv_done(u1_muldiv_done), .busy(u1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk(input logic vid, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic vex,
                              input logic [6:0] op, input logic [4:0] rd, input logic rd_en,
                              input logic md, input logic is_div, input logic br);
      in_t r;
      r.vid = vid; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.vex = vex;
      r.op = op; r.rd = rd; r.rd_en = rd_en; r.md = md; r.is_div = is_div; r.br = br;
      return r;
   endfunction

   task automatic drive(input in_t i);
      valid_id         = i.vid;
      rs1_addr_id      = i.rs1;
      rs2_addr_id      = i.rs2;
      rs1_used_id      = i.u1;
      rs2_used_id      = i.u2;
      valid_ex         = i.vex;
      opcode_ex        = i.op;
      rd_addr_ex       = i.rd;
      rd_en_ex         = i.rd_en;
      muldiv_ex        = i.md;
      muldiv_is_div_ex = i.is_div;
      branch_taken_ex  = i.br;
   endtask

   task automatic compare(input string tag, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", tag, act, exp);
      end else begin
         $display("ok   %s outputs=%b", tag, act);
      end
   endtask

   task automatic add(input in_t i, input logic [8:0] e, input string t);
      vec_t v;
      v.in = i; v.exp = e; v.tag = t;
      tbl.push_back(v);
   endtask

   // One clock cycle: drive after the rising edge, check at the falling edge.
   task automatic step(input in_t i, input logic [8:0] e, input string t,
                       input bit use_u1, input bit chk);
      sb_t s;
      @(posedge clk);
      #1;
      drive(i);
      if (chk) begin
         s.exp = e; s.tag = t; s.use_u1 = use_u1;
         sb_q.push_back(s);
      end
      @(negedge clk);
      if (chk) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=%b expected=%b", t, act0, e);
         end else begin
            s = sb_q.pop_front();
            compare(s.tag, s.use_u1 ? act1 : act0, s.exp);
         end
      end
   endtask

   initial begin
      in_t idle, ld5_rs1, mul, div, mdlu, brlu;
      idle    = mk(0, 0, 0, 0, 0, 0, 7'd0,   0, 0, 0, 0, 0);
      ld5_rs1 = mk(1, 5, 7, 1, 1, 1, OP_LD,  5, 1, 0, 0, 0);
      mul     = mk(1, 1, 2, 1, 1, 1, OP_ADD, 3, 1, 1, 0, 0);
      div     = mk(1, 1, 2, 1, 1, 1, OP_ADD, 3, 1, 1, 1, 0);
      mdlu    = mk(1, 5, 7, 1, 1, 1, OP_LD,  5, 1, 1, 0, 0);
      brlu    = mk(1, 5, 7, 1, 1, 1, OP_LD,  5, 1, 0, 0, 1);

      // Reset held with a load-use pattern on the inputs: outputs stay low.
      rst_n = 1'b0;
      drive(ld5_rs1);
      #12;
      compare("reset_hold_u0", act0, 9'h000);
      compare("reset_hold_u1", act1, 9'h000);
      drive(idle);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle and short multi-cycle vectors, applied back to back.
      add(idle,    9'h000,                "idle");
      add(ld5_rs1, SIF | SID | BUB,       "lu_c0");
      add(ld5_rs1, SIF | SID | BUB | BUSY, "lu_c1");
      add(idle,    9'h000,                "lu_c2");
      add(mk(1, 0, 9, 1, 1, 1, OP_LD, 0, 1, 0, 0, 0), 9'h000, "ld_x0");
      add(mk(1, 3, 5, 1, 0, 1, OP_LD, 5, 1, 0, 0, 0), 9'h000, "rs2_unused");
      add(mk(1, 3, 5, 1, 1, 1, OP_LD, 5, 1, 0, 0, 0), SIF | SID | BUB, "rs2_lu_c0");
      add(idle,    SIF | SID | BUB | BUSY, "rs2_lu_c1");
      add(mk(0, 5, 7, 1, 1, 1, OP_LD,  5, 1, 0, 0, 0), 9'h000, "id_invalid");
      add(mk(1, 5, 7, 1, 1, 0, OP_LD,  5, 1, 0, 0, 0), 9'h000, "ex_invalid");
      add(mk(1, 5, 7, 1, 1, 1, OP_LD,  5, 0, 0, 0, 0), 9'h000, "no_rd_en");
      add(mk(1, 5, 7, 1, 1, 1, OP_ADD, 5, 1, 0, 0, 0), 9'h000, "not_load");
      add(brlu,    FIF | FID,             "br_over_lu");
      add(mk(1, 5, 7, 1, 1, 1, OP_ADD, 5, 1, 1, 1, 1), FIF | FID, "br_over_md");
      add(ld5_rs1, SIF | SID | BUB,       "lu2_c0");
      add(mk(1, 5, 7, 1, 1, 1, OP_ADD, 5, 1, 1, 1, 1), SIF | SID | BUB | BUSY, "lu_ignores_ex");
      add(idle,    9'h000,                "lu2_c2");
      add(mul,     GO | SIF | SID | SEX,  "mul_c0");
      add(mul,     SIF | SID | SEX | BUSY, "mul_c1");
      add(mul,     DONE | BUSY,           "mul_c2");
      add(idle,    9'h000,                "mul_after");
      add(mdlu,    GO | SIF | SID | SEX,  "md_over_lu_c0");
      add(brlu,    SIF | SID | SEX | BUSY, "md_ignores_br");
      add(mdlu,    DONE | BUSY,           "md_over_lu_c2");
      add(idle,    9'h000,                "idle_end");
      for (int k = 0; k < tbl.size(); k++)
         step(tbl[k].in, tbl[k].exp, tbl[k].tag, 1'b0, 1'b1);

      // DIV on u0: one go pulse, 33 stall cycles, done on the 34th EX cycle.
      step(div, GO | SIF | SID | SEX, "div_c0", 1'b0, 1'b1);
      for (int k = 1; k <= 32; k++)
         step(div, SIF | SID | SEX | BUSY, $sformatf("div_c%0d", k), 1'b0, 1'b1);
      step(div, DONE | BUSY, "div_c33", 1'b0, 1'b1);
      step(idle, 9'h000, "div_after", 1'b0, 1'b1);

      // MUL_LATENCY=1 on u1: go and done together, no stall, stays in RUN.
      step(mul,  GO | DONE, "mul1_c0", 1'b1, 1'b1);
      step(idle, 9'h000,    "mul1_c1", 1'b1, 1'b1);
      step(idle, 9'h000,    "settle",  1'b0, 1'b0);
      step(idle, 9'h000,    "settle",  1'b0, 1'b0);

      // Reset in the middle of a DIV.
      for (int k = 0; k < 10; k++)
         step(div, (k == 0) ? (GO | SIF | SID | SEX) : (SIF | SID | SEX | BUSY),
              $sformatf("rdiv_c%0d", k), 1'b0, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      compare("rst_async_u0", act0, 9'h000);
      compare("rst_async_u1", act1, 9'h000);
      drive(idle);
      @(negedge clk);
      rst_n = 1'b1;
      step(idle, 9'h000,               "post_rst_idle", 1'b0, 1'b1);
      step(mul,  GO | SIF | SID | SEX,  "post_rst_mul_c0", 1'b0, 1'b1);
      step(mul,  SIF | SID | SEX | BUSY, "post_rst_mul_c1", 1'b0, 1'b1);
      step(mul,  DONE | BUSY,           "post_rst_mul_c2", 1'b0, 1'b1);
      step(idle, 9'h000,               "post_rst_after", 1'b0, 1'b1);

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cprv_hazard_controller.md
Name: cprv_hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV64 core. It sits beside the EX-stage operand forwarding logic.
- It generates the stalls and bubbles that forwarding cannot cover:
  - Load-use hazards. Load data is forwarded only from WB, so a dependent consumer needs 2 bubbles.
  - Multi-cycle MUL/DIV occupancy of EX.
  - Taken-branch flushes.
- All outputs are combinational from registered state plus current-cycle inputs.

Parameters:
MUL_LATENCY, 3, cycles a MUL-class op occupies EX (>=1)
DIV_LATENCY, 34, cycles a DIV/REM-class op occupies EX (>=1)
CNT_WIDTH, $clog2(DIV_LATENCY+1), width of the busy counter (must also hold MUL_LATENCY)

Ports:
clk  input  1  core clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
valid_id  input  1  ID stage holds a real instruction
rs1_addr_id  input  5  rs1 of the ID instruction
rs2_addr_id  input  5  rs2 of the ID instruction
rs1_used_id  input  1  ID instruction reads rs1
rs2_used_id  input  1  ID instruction reads rs2
valid_ex  input  1  EX stage holds a real instruction
opcode_ex  input  7  EX opcode
rd_addr_ex  input  5  EX destination register
rd_en_ex  input  1  EX writes rd
muldiv_ex  input  1  EX instruction is an M-extension op
muldiv_is_div_ex  input  1  the M-op is DIV/DIVU/REM/REMU(W)
branch_taken_ex  input  1  EX resolved a taken branch or jump
stall_if  output  1  hold the PC and the IF/ID register
stall_id  output  1  hold the ID/EX register contents
stall_ex  output  1  hold the EX/MEM input (EX re-executes)
bubble_ex  output  1  load a NOP into ID/EX at the next edge
flush_if  output  1  invalidate IF/ID at the next edge
flush_id  output  1  invalidate ID/EX at the next edge
muldiv_go  output  1  1-cycle start pulse to the M-unit
muldiv_done  output  1  last EX cycle of an M-op
busy  output  1  state != RUN

Behaviour:
- States: RUN, LU_STALL, MD_BUSY. Reset state is RUN with cnt=0.
- While rst_n=0 all outputs are 0.
- Asserting reset mid-operation returns to RUN immediately and discards any pending stall.
- Definitions used below:
  - load_use = valid_ex & valid_id & rd_en_ex & (opcode_ex==7'b0000011) & (rd_addr_ex!=0) & ((rs1_used_id & rs1_addr_id==rd_addr_ex) | (rs2_used_id & rs2_addr_id==rd_addr_ex)).
  - md = valid_ex & muldiv_ex.
  - L = muldiv_is_div_ex ? DIV_LATENCY : MUL_LATENCY.
- RUN, priority branch > md > load_use (these are mutually exclusive in legal code; the priority is fixed anyway):
  - branch_taken_ex: flush_if=1, flush_id=1, no stall; stay in RUN.
  - md: muldiv_go=1.
    - If L==1: muldiv_done=1, no stall, stay in RUN.
    - Otherwise: stall_if=stall_id=stall_ex=1, cnt<=L-2, go to MD_BUSY.
  - load_use: stall_if=stall_id=1, bubble_ex=1, go to LU_STALL.
  - Otherwise: all outputs 0.
- LU_STALL (the load is now in MEM): stall_if=stall_id=1, bubble_ex=1 unconditionally, then go to RUN.
  - The consumer enters EX when the load is in WB.
  - Exactly 2 bubbles per load-use; the EX inputs are ignored in this state.
- MD_BUSY:
  - cnt!=0: stall_if=stall_id=stall_ex=1, cnt<=cnt-1.
  - cnt==0: no stall, muldiv_done=1, go to RUN.
  - Total stall cycles = L-1, so the M-op occupies EX for exactly L cycles.
  - muldiv_ex/branch/load_use inputs are ignored in MD_BUSY, so the held op does not retrigger.
- muldiv_go is asserted only in RUN, exactly once per M-op.
- busy is high in LU_STALL and MD_BUSY.
- A load with rd=x0, or a consumer reading only unused rs fields, produces no stall.
- An ID instruction with valid_id=0 never stalls.

Test Plan:
1. Load-use: EX `ld x5` (opcode 0000011, rd_en=1), ID `add x6,x5,x7` (rs1_used=1, rs1=5).
   - Required: cycles 0 and 1 have stall_if=stall_id=bubble_ex=1, busy=0 then 1.
   - Cycle 2: all outputs 0, state RUN.
2. x0 / unused operand:
   - EX `ld x0`, ID rs1=0 -> no stall.
   - EX `ld x5`, ID rs2=5 with rs2_used=0 -> no stall.
3. DIV (DIV_LATENCY=34), muldiv_ex=1, is_div=1:
   - Required: muldiv_go for 1 cycle; stall_ex high for 33 consecutive cycles.
   - muldiv_done in cycle 34; muldiv_go is never re-pulsed.
4. MUL with MUL_LATENCY=1 (parameter override):
   - Required: muldiv_go=muldiv_done=1 in the same cycle, no stall, stays in RUN.
5. branch_taken_ex=1 together with a load_use condition forced on the inputs:
   - Required: flush_if=flush_id=1, stall_if=0, state stays RUN.
6. Reset mid-DIV: drop rst_n at cycle 10 of a DIV.
   - Required: all outputs 0 asynchronously (before the next clk edge).
   - After release: state RUN, busy=0, a new MUL gives muldiv_go and stall_ex for 2 cycles.
